// File: rtl/history_buffer_if.sv
// rtl/history_buffer_if.sv - write/read handshake bundle for history_buffer
interface history_buffer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  logic                       write_en;
  logic [WIDTH-1:0]           in;
  logic                       rd_req;
  logic [$clog2(DEPTH)-1:0]   rd_age;
  logic [WIDTH-1:0]           rd_out;
  logic                       rd_valid;
  logic                       rd_hit;
  logic [$clog2(DEPTH):0]     count;

  modport master (
    output write_en, in, rd_req, rd_age,
    input  rd_out, rd_valid, rd_hit, count
  );

  modport slave (
    input  write_en, in, rd_req, rd_age,
    output rd_out, rd_valid, rd_hit, count
  );
endinterface

// File: rtl/history_buffer.sv
// rtl/history_buffer.sv - circular history of the last DEPTH writes, read by age with 1-cycle latency
module history_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int SAFE  = 0
) (
  input  logic              clk,
  input  logic              reset,
  history_buffer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rd_index;
  logic             hit;
  logic [WIDTH-1:0] miss_data;

  // Index and hit use pre-update wp/count, so a same-cycle write is not visible.
  assign rd_index  = wp - AW'(1) - bus.rd_age;
  assign hit       = {1'b0, bus.rd_age} < bus.count;
  assign miss_data = (SAFE != 0) ? {WIDTH{1'b0}} : {WIDTH{1'bx}};

  always_ff @(posedge clk) begin
    if (reset && bus.write_en) begin
      mem[wp] <= bus.in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp           <= '0;
      bus.count    <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_hit   <= 1'b0;
      bus.rd_out   <= '0;
    end else begin
      if (bus.write_en) begin
        wp <= wp + AW'(1);
        if (bus.count != CW'(DEPTH)) begin
          bus.count <= bus.count + CW'(1);
        end
      end
      if (bus.rd_req) begin
        bus.rd_valid <= 1'b1;
        bus.rd_hit   <= hit;
        bus.rd_out   <= hit ? mem[rd_index] : miss_data;
      end else begin
        bus.rd_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_history_buffer.sv
// tb/tb_history_buffer.sv - directed self-checking bench for history_buffer
module tb_history_buffer;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  history_buffer_if #(.WIDTH(32), .DEPTH(8)) bus ();

  history_buffer #(.WIDTH(32), .DEPTH(8), .SAFE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic we, input logic [31:0] d, input logic rq, input logic [2:0] age);
    bus.write_en = we;
    bus.in       = d;
    bus.rd_req   = rq;
    bus.rd_age   = age;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 3'd0);
    cyc(1'b0, 32'h0, 1'b0, 3'd0);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.rd_valid); end
    checks++; if (bus.rd_hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", bus.rd_hit); end
    checks++; if (bus.rd_out !== 32'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", bus.rd_out); end
    cyc(1'b0, 32'h0, 1'b1, 3'd0);
    checks++; if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL post_reset_valid got=%b exp=1", bus.rd_valid); end
    checks++; if (bus.rd_hit !== 1'b0) begin failures++; $display("FAIL post_reset_hit got=%b exp=0", bus.rd_hit); end
    checks++; if (bus.rd_out !== 32'h0) begin failures++; $display("FAIL post_reset_out got=%h exp=0", bus.rd_out); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_out [4];
    logic        exp_hit [4];
    exp_out = '{32'd3, 32'd2, 32'd1, 32'd0};
    exp_hit = '{1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int i = 1; i <= 3; i++) cyc(1'b1, 32'(i), 1'b0, 3'd0);
    checks++; if (bus.count !== 4'd3) begin failures++; $display("FAIL basic_count got=%0d exp=3", bus.count); end
    for (int a = 0; a < 4; a++) begin
      cyc(1'b0, 32'h0, 1'b1, 3'(a));
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_hit !== exp_hit[a] || bus.rd_out !== exp_out[a]) begin
        failures++;
        $display("FAIL basic_age%0d got v=%b h=%b d=%h exp v=1 h=%b d=%h",
                 a, bus.rd_valid, bus.rd_hit, bus.rd_out, exp_hit[a], exp_out[a]);
      end
    end
    cyc(1'b0, 32'h0, 1'b0, 3'd0);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_hit !== 1'b0 || bus.rd_out !== 32'h0) begin
      failures++;
      $display("FAIL idle_hold got v=%b h=%b d=%h exp v=0 h=0 d=0", bus.rd_valid, bus.rd_hit, bus.rd_out);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 1; i <= 10; i++) cyc(1'b1, 32'(i), 1'b0, 3'd0);
    checks++; if (bus.count !== 4'd8) begin failures++; $display("FAIL wrap_count got=%0d exp=8", bus.count); end
    cyc(1'b0, 32'h0, 1'b1, 3'd0);
    checks++;
    if (bus.rd_hit !== 1'b1 || bus.rd_out !== 32'd10) begin
      failures++; $display("FAIL wrap_age0 got h=%b d=%0d exp h=1 d=10", bus.rd_hit, bus.rd_out);
    end
    cyc(1'b0, 32'h0, 1'b1, 3'd7);
    checks++;
    if (bus.rd_hit !== 1'b1 || bus.rd_out !== 32'd3) begin
      failures++; $display("FAIL wrap_age7 got h=%b d=%0d exp h=1 d=3", bus.rd_hit, bus.rd_out);
    end
    cyc(1'b0, 32'h0, 1'b1, 3'd4);
    checks++;
    if (bus.rd_hit !== 1'b1 || bus.rd_out !== 32'd6) begin
      failures++; $display("FAIL wrap_age4 got h=%b d=%0d exp h=1 d=6", bus.rd_hit, bus.rd_out);
    end
  endtask

  task automatic test_collision();
    apply_reset();
    cyc(1'b1, 32'h44, 1'b0, 3'd0);
    cyc(1'b1, 32'h55, 1'b1, 3'd0);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_hit !== 1'b1 || bus.rd_out !== 32'h44) begin
      failures++; $display("FAIL collide_read got v=%b h=%b d=%h exp v=1 h=1 d=44", bus.rd_valid, bus.rd_hit, bus.rd_out);
    end
    cyc(1'b0, 32'h0, 1'b1, 3'd0);
    checks++;
    if (bus.rd_hit !== 1'b1 || bus.rd_out !== 32'h55) begin
      failures++; $display("FAIL collide_after got h=%b d=%h exp h=1 d=55", bus.rd_hit, bus.rd_out);
    end
  endtask

  task automatic test_gaps();
    apply_reset();
    cyc(1'b1, 32'hA, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'hDEAD, 1'b0, 3'd0);
    cyc(1'b1, 32'hB, 1'b0, 3'd0);
    checks++; if (bus.count !== 4'd2) begin failures++; $display("FAIL gap_count got=%0d exp=2", bus.count); end
    cyc(1'b0, 32'h0, 1'b1, 3'd1);
    checks++;
    if (bus.rd_hit !== 1'b1 || bus.rd_out !== 32'hA) begin
      failures++; $display("FAIL gap_age1 got h=%b d=%h exp h=1 d=a", bus.rd_hit, bus.rd_out);
    end
    cyc(1'b0, 32'h0, 1'b1, 3'd2);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_hit !== 1'b0) begin
      failures++; $display("FAIL gap_age2 got v=%b h=%b exp v=1 h=0", bus.rd_valid, bus.rd_hit);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, 3'd0);
    checks++; if (bus.count !== 4'd5) begin failures++; $display("FAIL mid_precount got=%0d exp=5", bus.count); end
    reset = 1'b0;
    cyc(1'b1, 32'h999, 1'b1, 3'd0);
    reset = 1'b1;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.count !== 4'd0 || bus.rd_out !== 32'h0) begin
      failures++; $display("FAIL mid_reset got v=%b c=%0d d=%h exp v=0 c=0 d=0", bus.rd_valid, bus.count, bus.rd_out);
    end
    cyc(1'b0, 32'h0, 1'b1, 3'd0);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_hit !== 1'b0) begin
      failures++; $display("FAIL mid_after_read got v=%b h=%b exp v=1 h=0", bus.rd_valid, bus.rd_hit);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b0;
    bus.write_en = 1'b0;
    bus.in       = '0;
    bus.rd_req   = 1'b0;
    bus.rd_age   = '0;
    test_reset();
    test_back_to_back();
    test_wrap();
    test_collision();
    test_gaps();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
